fork_rr_n: RTL and testbench



---
 rtl/fork_pkg.sv | 27 ++
 rtl/fork_fifo.sv | 79 +++++++
 rtl/fork_rr_n.sv | 152 +++++++++++++++
 tb/tb_fork_rr_n.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fork_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fork_pkg
//  Description : Shared constants and helpers for the channel fork primitives.
//                Arbitration mode encodings and a ceiling-log2 helper used to
//                size buffer pointers, occupancy counters and port pointers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fork_pkg;

  localparam int FORK_MODE_STRICT = 0;
  localparam int FORK_MODE_SKIP   = 1;

  // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(4) = 2.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fork_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fork_fifo
//  Description : Input buffer for the channel primitives. Circular buffer of
//                DEPTH entries (power of two, >= 2) with registered head
//                output; no write-to-read bypass, so a word written in cycle t
//                is visible on rd_data from cycle t+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module fork_fifo
  import fork_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for pointers, occupancy and storage; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
    end
  end

  // Control state; asynchronous reset empties the buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/fork_rr_n.sv
`default_nettype none
// ============================================================================
//  Module      : fork_rr_n
//  Description : Buffered 1-to-N round-robin distributor using the pull
//                handshake (consumer request, fork valid). MODE selects strict
//                round robin or skip-idle round robin. The arbitration pointer
//                only advances on a real transfer.
//                Optional per-port dequeue counters are built when the macro
//                FORK_RR_STATS_EN is defined (adds stat_clear / stat_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module fork_rr_n
  import fork_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int DEPTH      = 2,
  parameter int MODE       = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           channel_read_data,
  input  logic                            channel_read_valid,
  output logic                            channel_read_request,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] p_read_data,
  input  logic [NUM_PORTS-1:0]            p_read_request,
  output logic [NUM_PORTS-1:0]            p_read_valid
`ifdef FORK_RR_STATS_EN
  ,
  input  logic                            stat_clear,
  output logic [NUM_PORTS*32-1:0]         stat_count
`endif
);

  localparam int PTR_W = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      sel_idx;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  deq;

  // Cyclic increment for port indices; with NUM_PORTS=1 this always yields 0,
  // so the pointer is pinned to port 0 and the block degenerates to a FIFO.
  function automatic logic [PTR_W-1:0] port_add(input logic [PTR_W-1:0] base,
                                                input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_PORTS) begin
      s = s - NUM_PORTS;
    end
    return PTR_W'(s);
  endfunction

  // Upstream is only offered a slot when the buffer has room and reset is
  // released; the request depends on registered occupancy only.
  assign channel_read_request = reset && !fifo_full;
  assign deq                  = !fifo_empty && p_read_request[sel_idx];

  fork_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (channel_read_valid && channel_read_request),
    .wr_data (channel_read_data),
    .full    (fifo_full),
    .rd_en   (deq),
    .rd_data (head_data),
    .empty   (fifo_empty)
  );

  if (MODE == FORK_MODE_SKIP) begin : g_skip
    logic [PTR_W-1:0] grant;
    // First requesting port at or after ptr in cyclic order; falls back to
    // ptr when nobody requests, so that port is offered the word meanwhile.
    always_comb begin
      grant = ptr_q;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (p_read_request[port_add(ptr_q, k)]) begin
          grant = port_add(ptr_q, k);
        end
      end
    end
    assign sel_idx = grant;
  end else begin : g_strict
    assign sel_idx = ptr_q;
  end

  // Pointer moves past the served port only when a word actually leaves.
  always_comb begin
    ptr_d = deq ? port_add(sel_idx, 1) : ptr_q;
  end

  // Arbitration pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Port mux: the head word is presented only on the selected port; all other
  // data slices are held at zero.
  always_comb begin
    p_read_valid = '0;
    p_read_data  = '0;
    if (!fifo_empty) begin
      p_read_valid[sel_idx]                                  = 1'b1;
      p_read_data[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH] = head_data;
    end
  end

`ifdef FORK_RR_STATS_EN
  logic [31:0] stat_q [NUM_PORTS];
  logic [31:0] stat_d [NUM_PORTS];

  // Per-port dequeue counters; a clear in the same cycle as a dequeue wins.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clear) begin
        stat_d[i] = '0;
      end else if (deq && (sel_idx == PTR_W'(i))) begin
        stat_d[i] = stat_q[i] + 32'd1;
      end
    end
  end

  // Counter registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stat_out
    assign stat_count[gi*32 +: 32] = stat_q[gi];
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fork_rr_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fork_rr_n
//  Description : Self-checking bench for fork_rr_n. Two instances (strict and
//                skip-idle, 4 ports, depth 2) share the upstream channel and
//                are compared every cycle against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fork_rr_n;

  localparam int DW  = 16;
  localparam int NP  = 4;
  localparam int DEP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      reset;
  logic [DW-1:0]             cdata;
  logic                      cval;
  logic [1:0]                creq;
  logic [1:0][NP*DW-1:0]     pdat;
  logic [1:0][NP-1:0]        preq;
  logic [1:0][NP-1:0]        pval;
`ifdef FORK_RR_STATS_EN
  logic                      sclr;
  logic [1:0][NP*32-1:0]     scnt;
`endif

  fork_rr_n #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .DEPTH(DEP), .MODE(0)) u_strict (
    .clk                  (clk),
    .reset                (reset),
    .channel_read_data    (cdata),
    .channel_read_valid   (cval),
    .channel_read_request (creq[0]),
    .p_read_data          (pdat[0]),
    .p_read_request       (preq[0]),
    .p_read_valid         (pval[0])
`ifdef FORK_RR_STATS_EN
    ,
    .stat_clear           (sclr),
    .stat_count           (scnt[0])
`endif
  );

  fork_rr_n #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .DEPTH(DEP), .MODE(1)) u_skip (
    .clk                  (clk),
    .reset                (reset),
    .channel_read_data    (cdata),
    .channel_read_valid   (cval),
    .channel_read_request (creq[1]),
    .p_read_data          (pdat[1]),
    .p_read_request       (preq[1]),
    .p_read_valid         (pval[1])
`ifdef FORK_RR_STATS_EN
    ,
    .stat_clear           (sclr),
    .stat_count           (scnt[1])
`endif
  );

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            mptr [2];
  int            mstat [2][NP];
  int            log_port[$];
  int            log_data[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model
  // by what the handshake rules say happens at the coming edge.
  task automatic cyc();
    int            sz, sel, idx;
    bit            found;
    logic [DW-1:0] head;
    logic          ecr, deq;
    logic [NP-1:0] ev;
    logic [NP*DW-1:0] ed;
    #1;
    for (int d = 0; d < 2; d++) begin
      sz   = (d == 0) ? q0.size() : q1.size();
      head = '0;
      if (sz > 0) head = (d == 0) ? q0[0] : q1[0];
      sel   = mptr[d];
      found = 1'b0;
      if (d == 1) begin
        for (int k = 0; k < NP; k++) begin
          idx = (mptr[d] + k) % NP;
          if (!found && preq[d][idx]) begin
            sel   = idx;
            found = 1'b1;
          end
        end
      end
      ecr = reset && (sz < DEP);
      ev  = '0;
      ed  = '0;
      deq = 1'b0;
      if (reset && sz > 0) begin
        ev[sel]         = 1'b1;
        ed[sel*DW +: DW] = head;
        deq             = preq[d][sel];
      end
      chk($sformatf("d%0d_creq", d), 64'(creq[d]), 64'(ecr));
      chk($sformatf("d%0d_valid", d), 64'(pval[d]), 64'(ev));
      chk($sformatf("d%0d_data", d), 64'(pdat[d]), 64'(ed));
`ifdef FORK_RR_STATS_EN
      for (int p = 0; p < NP; p++)
        chk($sformatf("d%0d_stat%0d", d, p), 64'(scnt[d][p*32 +: 32]), 64'(32'(mstat[d][p])));
`endif
      if (d == 0) begin
        for (int p = 0; p < NP; p++) begin
          if (pval[0][p] && preq[0][p]) begin
            log_port.push_back(p);
            log_data.push_back(int'(pdat[0][p*DW +: DW]));
          end
        end
      end
      if (!reset) begin
        if (d == 0) q0.delete(); else q1.delete();
        mptr[d] = 0;
        for (int p = 0; p < NP; p++) mstat[d][p] = 0;
      end else begin
        if (deq) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          mptr[d] = (sel + 1) % NP;
          mstat[d][sel]++;
        end
`ifdef FORK_RR_STATS_EN
        if (sclr) for (int p = 0; p < NP; p++) mstat[d][p] = 0;
`endif
        if (cval && ecr) begin
          if (d == 0) q0.push_back(cdata); else q1.push_back(cdata);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    cval  = 1'b0;
    cdata = '0;
    preq  = '0;
`ifdef FORK_RR_STATS_EN
    sclr  = 1'b0;
`endif
    mptr[0] = 0;
    mptr[1] = 0;
    for (int p = 0; p < NP; p++) begin
      mstat[0][p] = 0;
      mstat[1][p] = 0;
    end

    // Reset state.
    repeat (2) cyc();
    reset = 1'b1;

    // All requests high, words 1..8 back to back.
    preq[0] = 4'hF;
    preq[1] = 4'hF;
    log_port.delete();
    log_data.delete();
    for (int i = 1; i <= 8; i++) begin
      cdata = 16'(i);
      cval  = 1'b1;
      cyc();
    end
    cval = 1'b0;
    repeat (4) cyc();
    chk("rr_log_len", 64'(log_port.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < log_port.size()) begin
        chk($sformatf("rr_port%0d", k), 64'(log_port[k]), 64'(k % NP));
        chk($sformatf("rr_word%0d", k), 64'(log_data[k]), 64'(k + 1));
      end
    end

    // Strict stalls on idle port 1; skip-idle serves only ports 2 and 3.
    preq[0] = 4'b1101;
    preq[1] = 4'b1100;
    for (int i = 1; i <= 6; i++) begin
      cdata = 16'(16'h20 + i);
      cval  = 1'b1;
      cyc();
    end
    repeat (2) cyc();
    // Strict buffer is full; port 1 now requests while upstream keeps offering.
    preq[0] = 4'hF;
    cdata   = 16'h0031;
    cyc();
    cyc();
    cval = 1'b0;
    repeat (6) cyc();

    // Reset with two buffered words; those words must never appear.
    preq = '0;
    cdata = 16'h0041; cval = 1'b1; cyc();
    cdata = 16'h0042; cyc();
    cval = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    preq[0] = 4'hF;
    preq[1] = 4'hF;
    log_port.delete();
    log_data.delete();
    cdata = 16'h0055; cval = 1'b1; cyc();
    cval = 1'b0;
    repeat (3) cyc();
    chk("rst_log_len", 64'(log_port.size()), 64'd1);
    if (log_port.size() > 0) begin
      chk("rst_port", 64'(log_port[0]), 64'd0);
      chk("rst_word", 64'(log_data[0]), 64'h55);
    end

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      cval    = ($urandom_range(0, 3) != 0);
      cdata   = 16'($urandom);
      preq[0] = 4'($urandom);
      preq[1] = 4'($urandom);
`ifdef FORK_RR_STATS_EN
      sclr    = ($urandom_range(0, 49) == 0);
`endif
      cyc();
    end
    cval = 1'b0;
`ifdef FORK_RR_STATS_EN
    sclr = 1'b0;
`endif
    preq = '0;

`ifdef FORK_RR_STATS_EN
    // Ten words strict over four ports, then clear together with a dequeue.
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    preq[0] = 4'hF;
    preq[1] = 4'hF;
    for (int i = 1; i <= 10; i++) begin
      cdata = 16'(i);
      cval  = 1'b1;
      cyc();
    end
    cval = 1'b0;
    repeat (3) cyc();
    chk("stat_p0", 64'(scnt[0][0*32 +: 32]), 64'd3);
    chk("stat_p1", 64'(scnt[0][1*32 +: 32]), 64'd3);
    chk("stat_p2", 64'(scnt[0][2*32 +: 32]), 64'd2);
    chk("stat_p3", 64'(scnt[0][3*32 +: 32]), 64'd2);
    cdata = 16'h0077; cval = 1'b1; cyc();
    cval = 1'b0;
    sclr = 1'b1;
    cyc();
    sclr = 1'b0;
    chk("stat_clr", 64'(scnt[0] == '0), 64'd1);
    cyc();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
